// File: rtl/mdu_iter_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module : mdu_iter_pkg                                                      |
// | Brief  : Op codes, FSM state encodings and iteration count for mdu_iter.   |
// | Rev    : 1.0  initial release                                              |
// +----------------------------------------------------------------------------+
package mdu_iter_pkg;

    typedef logic [1:0] mdu_op_t;

    localparam mdu_op_t c_OP_MULT  = 2'd0;
    localparam mdu_op_t c_OP_MULTU = 2'd1;
    localparam mdu_op_t c_OP_DIV   = 2'd2;
    localparam mdu_op_t c_OP_DIVU  = 2'd3;

    localparam logic [1:0] c_ST_IDLE = 2'd0;
    localparam logic [1:0] c_ST_CALC = 2'd1;
    localparam logic [1:0] c_ST_FIX  = 2'd2;
    localparam logic [1:0] c_ST_DONE = 2'd3;

    localparam int c_ITERS = 32;

    // Bit 0 clear marks the signed variants (MULT, DIV); bit 1 set marks divides.
    function automatic logic op_is_signed(input mdu_op_t op);
        return ~op[0];
    endfunction

endpackage
`default_nettype wire

// File: rtl/mdu_iter_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module : mdu_iter_if                                                       |
// | Brief  : Core <-> multiply/divide unit request, MTHI/MTLO and HI/LO bus.   |
// | Rev    : 1.0  initial release                                              |
// +----------------------------------------------------------------------------+
interface mdu_iter_if #(
    parameter int WIDTH = 32
);
    logic             start;
    logic [1:0]       op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             hi_we;
    logic             lo_we;
    logic [WIDTH-1:0] wdata;
    logic             busy;
    logic             done;
    logic             div0;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;

    modport master (
        output start, op, a, b, hi_we, lo_we, wdata,
        input  busy, done, div0, hi, lo
    );

    modport slave (
        input  start, op, a, b, hi_we, lo_we, wdata,
        output busy, done, div0, hi, lo
    );
endinterface
`default_nettype wire

// File: rtl/mdu_iter_step.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module : mdu_step                                                          |
// | Brief  : Combinational add/sub step shared by multiply and divide paths.   |
// | Rev    : 1.0  initial release                                              |
// +----------------------------------------------------------------------------+
module mdu_step #(
    parameter int WIDTH = 33
) (
    input  wire logic [WIDTH-1:0] i_x,
    input  wire logic [WIDTH-1:0] i_y,
    input  wire logic             i_sub,
    output logic      [WIDTH-1:0] o_sum,
    output logic                  o_borrow
);
    logic [WIDTH:0] w_full;

    // Subtract as x + ~y + 1; a missing carry out means y > x.
    assign w_full   = {1'b0, i_x} + {1'b0, (i_sub ? ~i_y : i_y)} + {{WIDTH{1'b0}}, i_sub};
    assign o_sum    = w_full[WIDTH-1:0];
    assign o_borrow = i_sub & ~w_full[WIDTH];
endmodule
`default_nettype wire

// File: rtl/mdu_iter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module : mdu_iter                                                          |
// | Brief  : Iterative MULT/MULTU/DIV/DIVU unit with HI/LO registers.          |
// |          Divider present only when MDU_DIV_EN is defined.                  |
// | Rev    : 1.0  initial release                                              |
// +----------------------------------------------------------------------------+
module mdu_iter
    import mdu_iter_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  wire logic   clk,
    input  wire logic   rst_n,
    mdu_iter_if.slave   bus
);
    localparam int               c_CNT_W = $clog2(c_ITERS);
    localparam logic [c_CNT_W-1:0] c_LAST  = c_CNT_W'(c_ITERS - 1);

    logic [1:0]         r_state;
    logic [c_CNT_W-1:0] r_cnt;
    mdu_op_t            r_op;
    logic               r_sign_q;
    logic [2*WIDTH-1:0] r_acc;
    logic [WIDTH-1:0]   r_opb;
    logic [WIDTH-1:0]   r_hi;
    logic [WIDTH-1:0]   r_lo;
    logic               r_busy;
    logic               r_done;
    logic               r_div0;

    logic               w_signed_in;
    logic [WIDTH-1:0]   w_a_mag;
    logic [WIDTH-1:0]   w_b_mag;
    logic               w_skip;
    logic               w_div0;
    logic [WIDTH:0]     w_x;
    logic [WIDTH:0]     w_y;
    logic               w_sub;
    logic [WIDTH:0]     w_sum;
    logic               w_borrow;
    logic [2*WIDTH-1:0] w_acc_next;
    logic [WIDTH-1:0]   w_hi_fix;
    logic [WIDTH-1:0]   w_lo_fix;

    assign w_signed_in = op_is_signed(bus.op);
    assign w_a_mag     = (w_signed_in && bus.a[WIDTH-1]) ? (~bus.a + 1'b1) : bus.a;
    assign w_b_mag     = (w_signed_in && bus.b[WIDTH-1]) ? (~bus.b + 1'b1) : bus.b;

    mdu_step #(.WIDTH(WIDTH + 1)) u_step (
        .i_x      (w_x),
        .i_y      (w_y),
        .i_sub    (w_sub),
        .o_sum    (w_sum),
        .o_borrow (w_borrow)
    );

`ifdef MDU_DIV_EN
    logic r_sign_r;

    assign w_skip = bus.op[1] && (bus.b == '0);
    assign w_div0 = w_skip;
    // Divide: partial remainder with next dividend bit vs divisor; multiply: hi half + gated multiplicand.
    assign w_x    = r_op[1] ? r_acc[2*WIDTH-1:WIDTH-1] : {1'b0, r_acc[2*WIDTH-1:WIDTH]};
    assign w_y    = {1'b0, ((r_op[1] || r_acc[0]) ? r_opb : '0)};
    assign w_sub  = r_op[1];

    always_comb begin
        w_acc_next = {w_sum, r_acc[WIDTH-1:1]};
        w_hi_fix   = r_acc[2*WIDTH-1:WIDTH];
        w_lo_fix   = r_acc[WIDTH-1:0];
        if (r_op[1]) begin
            w_acc_next = w_borrow ? {r_acc[2*WIDTH-2:0], 1'b0}
                                  : {w_sum[WIDTH-1:0], r_acc[WIDTH-2:0], 1'b1};
            if (op_is_signed(r_op) && r_sign_q) w_lo_fix = ~r_acc[WIDTH-1:0] + 1'b1;
            if (op_is_signed(r_op) && r_sign_r) w_hi_fix = ~r_acc[2*WIDTH-1:WIDTH] + 1'b1;
        end else if (op_is_signed(r_op) && r_sign_q) begin
            {w_hi_fix, w_lo_fix} = ~r_acc + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                                   r_sign_r <= 1'b0;
        else if (r_state == c_ST_IDLE && bus.start)   r_sign_r <= bus.a[WIDTH-1];
    end
`else
    logic w_unused;

    // Without the divider every divide request completes immediately and untouched.
    assign w_skip   = bus.op[1];
    assign w_div0   = 1'b0;
    assign w_x      = {1'b0, r_acc[2*WIDTH-1:WIDTH]};
    assign w_y      = {1'b0, (r_acc[0] ? r_opb : '0)};
    assign w_sub    = 1'b0;
    assign w_unused = &{1'b0, w_borrow, r_op[1]};

    always_comb begin
        w_acc_next = {w_sum, r_acc[WIDTH-1:1]};
        {w_hi_fix, w_lo_fix} = r_acc;
        if (op_is_signed(r_op) && r_sign_q) {w_hi_fix, w_lo_fix} = ~r_acc + 1'b1;
    end
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= c_ST_IDLE;
            r_cnt    <= '0;
            r_op     <= c_OP_MULT;
            r_sign_q <= 1'b0;
            r_acc    <= '0;
            r_opb    <= '0;
            r_hi     <= '0;
            r_lo     <= '0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
            r_div0   <= 1'b0;
        end else begin
            r_done <= 1'b0;
            r_div0 <= 1'b0;
            case (r_state)
                c_ST_IDLE: begin
                    if (bus.start) begin
                        r_op     <= bus.op;
                        r_sign_q <= bus.a[WIDTH-1] ^ bus.b[WIDTH-1];
                        r_cnt    <= '0;
                        r_acc    <= {{WIDTH{1'b0}}, w_a_mag};
                        r_opb    <= w_b_mag;
                        r_busy   <= 1'b1;
                        if (w_skip) begin
                            r_state <= c_ST_DONE;
                            r_done  <= 1'b1;
                            r_div0  <= w_div0;
                        end else begin
                            r_state <= c_ST_CALC;
                        end
                    end else begin
                        if (bus.hi_we) r_hi <= bus.wdata;
                        if (bus.lo_we) r_lo <= bus.wdata;
                    end
                end
                c_ST_CALC: begin
                    r_acc <= w_acc_next;
                    r_cnt <= r_cnt + 1'b1;
                    if (r_cnt == c_LAST) r_state <= c_ST_FIX;
                end
                c_ST_FIX: begin
                    r_hi    <= w_hi_fix;
                    r_lo    <= w_lo_fix;
                    r_done  <= 1'b1;
                    r_state <= c_ST_DONE;
                end
                default: begin
                    r_busy  <= 1'b0;
                    r_state <= c_ST_IDLE;
                end
            endcase
        end
    end

    assign bus.busy = r_busy;
    assign bus.done = r_done;
    assign bus.div0 = r_div0;
    assign bus.hi   = r_hi;
    assign bus.lo   = r_lo;
endmodule
`default_nettype wire

// File: tb/tb_mdu_iter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module : tb_mdu_iter                                                       |
// | Brief  : Directed self-checking bench for mdu_iter (MDU_DIV_EN aware).     |
// | Rev    : 1.0  initial release                                              |
// +----------------------------------------------------------------------------+
module tb_mdu_iter;
    logic clk;
    logic rst_n;
    int   n_checks;
    int   n_fail;

    mdu_iter_if #(.WIDTH(32)) bus ();

    mdu_iter #(.WIDTH(32)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Issue one request and return the number of edges until done is seen (1 = next cycle).
    task automatic run_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                          output int lat);
        bus.op    = op;
        bus.a     = a;
        bus.b     = b;
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        lat = 1;
        while (bus.done !== 1'b1 && lat < 60) begin
            tick();
            lat++;
        end
    endtask

    task automatic write_hilo(input logic [31:0] hv, input logic [31:0] lv);
        bus.hi_we = 1'b1; bus.wdata = hv; tick(); bus.hi_we = 1'b0;
        bus.lo_we = 1'b1; bus.wdata = lv; tick(); bus.lo_we = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #1;
        n_checks++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got %b want 0", bus.busy); end
        n_checks++; if (bus.done !== 1'b0) begin n_fail++; $display("FAIL reset_done got %b want 0", bus.done); end
        n_checks++; if (bus.div0 !== 1'b0) begin n_fail++; $display("FAIL reset_div0 got %b want 0", bus.div0); end
        n_checks++; if (bus.hi !== 32'h0) begin n_fail++; $display("FAIL reset_hi got %h want 0", bus.hi); end
        n_checks++; if (bus.lo !== 32'h0) begin n_fail++; $display("FAIL reset_lo got %h want 0", bus.lo); end
        tick(); tick();
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_mthi_mtlo();
        bus.hi_we = 1'b1; bus.wdata = 32'h0000_1234; tick(); bus.hi_we = 1'b0;
        n_checks++; if (bus.hi !== 32'h0000_1234) begin n_fail++; $display("FAIL mthi got %h want 00001234", bus.hi); end
        n_checks++; if (bus.lo !== 32'h0) begin n_fail++; $display("FAIL mthi_lo_kept got %h want 0", bus.lo); end
        bus.lo_we = 1'b1; bus.wdata = 32'h0000_abcd; tick(); bus.lo_we = 1'b0;
        n_checks++; if (bus.lo !== 32'h0000_abcd) begin n_fail++; $display("FAIL mtlo got %h want 0000abcd", bus.lo); end
    endtask

    task automatic test_multu();
        int lat;
        run_op(2'd1, 32'hffff_ffff, 32'hffff_ffff, lat);
        n_checks++; if (lat !== 34) begin n_fail++; $display("FAIL multu_latency got %0d want 34", lat); end
        n_checks++; if (bus.hi !== 32'hffff_fffe) begin n_fail++; $display("FAIL multu_hi got %h want fffffffe", bus.hi); end
        n_checks++; if (bus.lo !== 32'h0000_0001) begin n_fail++; $display("FAIL multu_lo got %h want 00000001", bus.lo); end
        n_checks++; if (bus.div0 !== 1'b0) begin n_fail++; $display("FAIL multu_div0 got %b want 0", bus.div0); end
        n_checks++; if (bus.busy !== 1'b1) begin n_fail++; $display("FAIL multu_busy_in_done got %b want 1", bus.busy); end
        tick();
        n_checks++; if (bus.done !== 1'b0 || bus.busy !== 1'b0) begin
            n_fail++; $display("FAIL multu_after got done=%b busy=%b want 0 0", bus.done, bus.busy); end
    endtask

    task automatic test_mult();
        int lat;
        run_op(2'd0, 32'hffff_fffd, 32'd5, lat);
        n_checks++; if (lat !== 34) begin n_fail++; $display("FAIL mult_latency got %0d want 34", lat); end
        n_checks++; if ({bus.hi, bus.lo} !== 64'hffff_ffff_ffff_fff1) begin
            n_fail++; $display("FAIL mult_neg got %h%h want ffffffff_fffffff1", bus.hi, bus.lo); end
        tick();
        run_op(2'd0, 32'hffff_fffc, 32'hffff_fffa, lat);
        n_checks++; if ({bus.hi, bus.lo} !== 64'd24) begin
            n_fail++; $display("FAIL mult_negneg got %h%h want 24", bus.hi, bus.lo); end
        tick();
        run_op(2'd0, 32'h8000_0000, 32'h8000_0000, lat);
        n_checks++; if ({bus.hi, bus.lo} !== 64'h4000_0000_0000_0000) begin
            n_fail++; $display("FAIL mult_minmin got %h%h want 40000000_00000000", bus.hi, bus.lo); end
        tick();
        run_op(2'd1, 32'h8000_0000, 32'd2, lat);
        n_checks++; if ({bus.hi, bus.lo} !== 64'h1_0000_0000) begin
            n_fail++; $display("FAIL multu_unsigned_top got %h%h want 00000001_00000000", bus.hi, bus.lo); end
        tick();
    endtask

    task automatic test_div();
        int lat;
`ifdef MDU_DIV_EN
        run_op(2'd2, 32'hffff_fff9, 32'd2, lat);
        n_checks++; if (lat !== 34) begin n_fail++; $display("FAIL div_latency got %0d want 34", lat); end
        n_checks++; if (bus.lo !== 32'hffff_fffd || bus.hi !== 32'hffff_ffff) begin
            n_fail++; $display("FAIL div_neg got lo=%h hi=%h want fffffffd ffffffff", bus.lo, bus.hi); end
        tick();
        run_op(2'd2, 32'h8000_0000, 32'hffff_ffff, lat);
        n_checks++; if (bus.lo !== 32'h8000_0000 || bus.hi !== 32'h0) begin
            n_fail++; $display("FAIL div_overflow got lo=%h hi=%h want 80000000 0", bus.lo, bus.hi); end
        tick();
        run_op(2'd3, 32'd100, 32'd7, lat);
        n_checks++; if (bus.lo !== 32'd14 || bus.hi !== 32'd2) begin
            n_fail++; $display("FAIL divu got lo=%h hi=%h want e 2", bus.lo, bus.hi); end
        tick();
`else
        write_hilo(32'h55, 32'h55);
        run_op(2'd2, 32'hffff_fff9, 32'd2, lat);
        n_checks++; if (lat !== 1) begin n_fail++; $display("FAIL div_absent_latency got %0d want 1", lat); end
        n_checks++; if (bus.div0 !== 1'b0 || bus.hi !== 32'h55 || bus.lo !== 32'h55) begin
            n_fail++; $display("FAIL div_absent got div0=%b hi=%h lo=%h want 0 55 55", bus.div0, bus.hi, bus.lo); end
        tick();
`endif
        write_hilo(32'h55, 32'h55);
        run_op(2'd3, 32'd100, 32'd0, lat);
        n_checks++; if (lat !== 1) begin n_fail++; $display("FAIL div0_latency got %0d want 1", lat); end
`ifdef MDU_DIV_EN
        n_checks++; if (bus.div0 !== 1'b1) begin n_fail++; $display("FAIL div0_flag got %b want 1", bus.div0); end
`else
        n_checks++; if (bus.div0 !== 1'b0) begin n_fail++; $display("FAIL div0_flag got %b want 0", bus.div0); end
`endif
        n_checks++; if (bus.hi !== 32'h55 || bus.lo !== 32'h55) begin
            n_fail++; $display("FAIL div0_hilo got hi=%h lo=%h want 55 55", bus.hi, bus.lo); end
        tick();
        n_checks++; if (bus.busy !== 1'b0 || bus.div0 !== 1'b0) begin
            n_fail++; $display("FAIL div0_after got busy=%b div0=%b want 0 0", bus.busy, bus.div0); end
    endtask

    task automatic test_start_ignored();
        int lat;
        int pulses;
        write_hilo(32'h0bad_0000, 32'h0);
        bus.op = 2'd1; bus.a = 32'd7; bus.b = 32'd6; bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        for (int i = 0; i < 4; i++) tick();
        // Cycle N+5: competing start, plus an MTHI strobe while busy.
        bus.a = 32'd9; bus.start = 1'b1; bus.hi_we = 1'b1; bus.wdata = 32'hdead;
        tick();
        bus.start = 1'b0; bus.hi_we = 1'b0;
        n_checks++; if (bus.hi !== 32'h0bad_0000) begin n_fail++; $display("FAIL busy_write got hi=%h want 0bad0000", bus.hi); end
        lat = 6;
        while (bus.done !== 1'b1 && lat < 60) begin tick(); lat++; end
        n_checks++; if (lat !== 34) begin n_fail++; $display("FAIL ignored_start_latency got %0d want 34", lat); end
        n_checks++; if (bus.lo !== 32'd42 || bus.hi !== 32'd0) begin
            n_fail++; $display("FAIL ignored_start_result got hi=%h lo=%h want 0 2a", bus.hi, bus.lo); end
        pulses = 0;
        for (int i = 0; i < 40; i++) begin tick(); if (bus.done === 1'b1) pulses++; end
        n_checks++; if (pulses !== 0) begin n_fail++; $display("FAIL ignored_start_extra_done got %0d want 0", pulses); end
    endtask

    task automatic test_start_with_write();
        int lat;
        write_hilo(32'h1111, 32'h2222);
        bus.hi_we = 1'b1; bus.wdata = 32'h777;
        run_op(2'd1, 32'd2, 32'd3, lat);
        bus.hi_we = 1'b0;
        n_checks++; if (lat !== 34) begin n_fail++; $display("FAIL start_write_latency got %0d want 34", lat); end
        n_checks++; if (bus.hi !== 32'd0 || bus.lo !== 32'd6) begin
            n_fail++; $display("FAIL start_write_result got hi=%h lo=%h want 0 6", bus.hi, bus.lo); end
        tick();
        write_hilo(32'h1111, 32'h2222);
        bus.op = 2'd1; bus.a = 32'd2; bus.b = 32'd3; bus.start = 1'b1;
        bus.hi_we = 1'b1; bus.wdata = 32'h777;
        tick();
        bus.start = 1'b0; bus.hi_we = 1'b0;
        n_checks++; if (bus.hi !== 32'h1111) begin n_fail++; $display("FAIL start_write_dropped got hi=%h want 1111", bus.hi); end
        lat = 1;
        while (bus.done !== 1'b1 && lat < 60) begin tick(); lat++; end
        tick();
    endtask

    task automatic test_back_to_back();
        int lat;
        run_op(2'd1, 32'd5, 32'd5, lat);
        // Start presented during DONE must be dropped.
        bus.a = 32'd3; bus.b = 32'd3; bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        n_checks++; if (bus.busy !== 1'b0 || bus.lo !== 32'd25) begin
            n_fail++; $display("FAIL start_in_done got busy=%b lo=%h want 0 19", bus.busy, bus.lo); end
        run_op(2'd1, 32'd3, 32'd3, lat);
        n_checks++; if (lat !== 34 || bus.lo !== 32'd9) begin
            n_fail++; $display("FAIL back_to_back got lat=%0d lo=%h want 34 9", lat, bus.lo); end
        tick();
    endtask

    task automatic test_reset_abort();
        int pulses;
        bus.op = 2'd1; bus.a = 32'd7; bus.b = 32'd6; bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        for (int i = 0; i < 9; i++) tick();
        #2;
        rst_n = 1'b0;
        #1;
        n_checks++; if (bus.busy !== 1'b0 || bus.hi !== 32'h0 || bus.lo !== 32'h0) begin
            n_fail++; $display("FAIL abort got busy=%b hi=%h lo=%h want 0 0 0", bus.busy, bus.hi, bus.lo); end
        tick();
        rst_n = 1'b1;
        pulses = 0;
        for (int i = 0; i < 40; i++) begin tick(); if (bus.done === 1'b1 || bus.busy === 1'b1) pulses++; end
        n_checks++; if (pulses !== 0) begin n_fail++; $display("FAIL abort_activity got %0d want 0", pulses); end
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        rst_n    = 1'b0;
        bus.start = 1'b0; bus.op = 2'd0; bus.a = '0; bus.b = '0;
        bus.hi_we = 1'b0; bus.lo_we = 1'b0; bus.wdata = '0;
        test_reset();
        test_mthi_mtlo();
        test_multu();
        test_mult();
        test_div();
        test_start_ignored();
        test_start_with_write();
        test_back_to_back();
        test_reset_abort();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
`default_nettype wire
